icap_reboot_ctrl: RTL and testbench
===================================

ICAP_REBOOT_CTRL -- requirements
Module: icap_reboot_ctrl

Interface
REQ-001 SHALL provide parameters:
- START_DELAY, default 15, cycles after reset before requests are accepted.
- SPI_OPCODE, default 8'h03, SPI read opcode placed in GENERAL_2.
- SLOT0_ADDR, default 24'h000000, flash address of image 0.
- SLOT1_ADDR, default 24'h060000, flash address of image 1.
- SLOT2_ADDR, default 24'h0C0000, flash address of image 2.
- SLOT3_ADDR, default 24'h120000, flash address of image 3.

REQ-002 SHALL provide ports, clock and reset first:
- fastclk, in, 1, sole clock; all logic on rising edge.
- reset, in, 1, asynchronous active-high reset.
- req, in, 1, reboot request, sampled each cycle.
- slot, in, 2, image select, sampled with req.
- icap_busy, in, 1, ICAP BUSY; while high, the current word is held.
- ack, out, 1, one-cycle pulse when a request is accepted.
- busy, out, 1, high from acceptance until sequence end.
- done, out, 1, one-cycle pulse after the last word is issued.
- icap_ce_n, out, 1, ICAP CE, active low.
- icap_wr_n, out, 1, ICAP WRITE, active low.
- icap_i, out, 16, ICAP data, bit-reversed within each byte.

REQ-003 SHALL use one clock, fastclk; reset is asynchronous and active-high, named reset.

Function
REQ-004 SHALL register every output; no combinational path from any input to any output.
REQ-005 SHALL count START_DELAY cycles after reset deassertion (counter saturates, 4+ bits); req is ignored, not queued, until the count completes.
REQ-006 SHALL implement states IDLE, SEQ (word index 0..11), DONE.
REQ-007 SHALL accept a request in IDLE when req=1 and the delay has expired, latching slot; ack=1 and busy=1 on the next cycle.
REQ-008 SHALL issue the word sequence starting the cycle after ack:
- AA99, 5566 (sync)
- 3261, SLOTn_ADDR[15:0] (GENERAL_1)
- 3281, {SPI_OPCODE, SLOTn_ADDR[23:16]} (GENERAL_2)
- 30A1, 000E (command register, REBOOT)
- 2000 four times (NOOP)
REQ-009 SHALL drive icap_ce_n=0 and icap_wr_n=0 on exactly the cycles a sequence word is presented.
REQ-010 SHALL drive icap_i[i]=word[7-i] for i=0..7 and icap_i[8+i]=word[15-i] for i=0..7.
REQ-011 SHALL advance the word index only on cycles where icap_busy=0; while icap_busy=1, hold word, ce_n and wr_n unchanged. Minimum sequence length is 12 cycles.
REQ-012 SHALL, after word 11 is accepted (icap_busy=0), enter DONE for one cycle:
- done=1, busy=0 next cycle, ce_n=1, wr_n=1, icap_i=16'hFFFF.
- Then return to IDLE.
REQ-013 SHALL ignore req and changes on slot from acceptance through DONE; a req held high re-triggers only once back in IDLE, with ack no earlier than 1 cycle after done.
REQ-014 SHALL, outside SEQ, hold icap_ce_n=1, icap_wr_n=1, icap_i=16'hFFFF.
REQ-015 SHALL treat simultaneous req and the final delay-counter cycle as not accepted; acceptance starts the cycle after the counter reaches START_DELAY.

Reset
REQ-016 SHALL, on reset assertion at any time including mid-sequence, immediately force:
- state=IDLE, delay counter=0, word index=0;
- ack=0, busy=0, done=0;
- icap_ce_n=1, icap_wr_n=1, icap_i=16'hFFFF.
REQ-017 SHALL restart the START_DELAY count after every reset deassertion.

Verification
REQ-018 Bench SHALL cover:
- Startup guard: req held high from reset release, START_DELAY=15 -> no ack before cycle 16; ack on first eligible cycle; exactly 12 write cycles follow.
- Slot 1, defaults, icap_busy=0 -> unreversed words AA99,5566,3261,0000,3281,0306,30A1,000E,2000x4; icap_i for AA99 = 16'h5599; done one cycle after the last NOOP.
- Busy stall: icap_busy=1 for 3 cycles during word 3 -> word held 4 cycles total, sequence 15 cycles, ce_n/wr_n low throughout.
- Slot 3: GEN1=0000, GEN2=0312; req pulses and slot toggles mid-sequence -> no extra ack, words unchanged.
- Reset at word 6 -> ce_n=wr_n=1, icap_i=FFFF, busy=0 immediately; after release, new req accepted only after a fresh START_DELAY.

Source files
------------

// File: rtl/icap_reboot_ctrl.sv
// Issues an ICAP reboot (IPROG) word sequence pointing the configuration logic
// at one of four flash images, after a start-up guard delay.
module icap_reboot_ctrl #(
    parameter int unsigned START_DELAY = 15,
    parameter logic [7:0]  SPI_OPCODE  = 8'h03,
    parameter logic [23:0] SLOT0_ADDR  = 24'h000000,
    parameter logic [23:0] SLOT1_ADDR  = 24'h060000,
    parameter logic [23:0] SLOT2_ADDR  = 24'h0C0000,
    parameter logic [23:0] SLOT3_ADDR  = 24'h120000
) (
    input  logic        fastclk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  slot,
    input  logic        icap_busy,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic        icap_ce_n,
    output logic        icap_wr_n,
    output logic [15:0] icap_i
);

    localparam int unsigned CNT_RAW = $clog2(START_DELAY + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 4) ? CNT_RAW : 4;
    localparam int unsigned IDX_W   = 4;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(11);
    localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(START_DELAY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ce_n_q, ce_n_d;
    logic [15:0]      data_q, data_d;
    logic             delay_done;
    logic             accept;

    function automatic logic [23:0] slot_addr(input logic [1:0] s);
        case (s)
            2'd0:    slot_addr = SLOT0_ADDR;
            2'd1:    slot_addr = SLOT1_ADDR;
            2'd2:    slot_addr = SLOT2_ADDR;
            default: slot_addr = SLOT3_ADDR;
        endcase
    endfunction

    function automatic logic [15:0] seq_word(input logic [IDX_W-1:0] idx, input logic [23:0] addr);
        case (idx)
            4'd0:    seq_word = 16'hAA99;
            4'd1:    seq_word = 16'h5566;
            4'd2:    seq_word = 16'h3261;
            4'd3:    seq_word = addr[15:0];
            4'd4:    seq_word = 16'h3281;
            4'd5:    seq_word = {SPI_OPCODE, addr[23:16]};
            4'd6:    seq_word = 16'h30A1;
            4'd7:    seq_word = 16'h000E;
            default: seq_word = 16'h2000;
        endcase
    endfunction

    // ICAP expects each byte presented MSB-first on bit 0
    function automatic logic [15:0] byte_swizzle(input logic [15:0] w);
        for (int i = 0; i < 8; i++) begin
            byte_swizzle[i]     = w[7-i];
            byte_swizzle[8 + i] = w[15-i];
        end
    endfunction

    assign delay_done = (cnt_q == DELAY_END);
    // ack_q blocks a second acceptance while waiting to enter SEQ
    assign accept     = (state_q == ST_IDLE) && !ack_q && req && delay_done;
    assign cnt_d      = delay_done ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            data_q  <= 16'hFFFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ce_n_q  <= ce_n_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    slot_d = slot;
                end else if (ack_q) begin
                    state_d = ST_SEQ;
                    idx_d   = '0;
                end
            end
            ST_SEQ: begin
                if (!icap_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the flops track the state exactly
    always_comb begin
        ack_d  = accept;
        busy_d = accept || (state_d == ST_SEQ);
        done_d = (state_d == ST_DONE);
        ce_n_d = (state_d != ST_SEQ);
        data_d = 16'hFFFF;
        if (state_d == ST_SEQ) begin
            data_d = byte_swizzle(seq_word(idx_d, slot_addr(slot_q)));
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign icap_ce_n = ce_n_q;
    assign icap_wr_n = ce_n_q;
    assign icap_i    = data_q;

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// Directed bench for icap_reboot_ctrl: start-up guard, per-slot word streams,
// BUSY stalls, mid-sequence disturbance and reset mid-sequence.
module tb_icap_reboot_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic [1:0]  slot;
    logic        icap_busy;
    logic        ack;
    logic        busy;
    logic        done;
    logic        icap_ce_n;
    logic        icap_wr_n;
    logic [15:0] icap_i;

    int checks = 0;
    int errors = 0;
    int n;

    icap_reboot_ctrl dut (
        .fastclk   (clk),
        .reset     (reset),
        .req       (req),
        .slot      (slot),
        .icap_busy (icap_busy),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .icap_ce_n (icap_ce_n),
        .icap_wr_n (icap_wr_n),
        .icap_i    (icap_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rev_bytes(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8 + i] = w[15-i];
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_word(input int k, input logic [15:0] gen1, input logic [15:0] gen2);
        case (k)
            0:       return 16'hAA99;
            1:       return 16'h5566;
            2:       return 16'h3261;
            3:       return gen1;
            4:       return 16'h3281;
            5:       return gen2;
            6:       return 16'h30A1;
            7:       return 16'h000E;
            default: return 16'h2000;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ce_n"}, 32'(icap_ce_n), 32'd1);
        check({tag, "_wr_n"}, 32'(icap_wr_n), 32'd1);
        check({tag, "_data"}, 32'(icap_i), 32'h0000FFFF);
    endtask

    // Returns the number of cycles until ack is seen, or -1 if the budget expires
    task automatic wait_ack(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Called at the negedge of the ack cycle; walks the 12 words then DONE
    task automatic expect_words(input logic [15:0] gen1, input logic [15:0] gen2,
                                input int stall_word, input int stall_len,
                                input bit disturb, input int exp_cycles);
        int wr_cycles = 0;
        int hold;
        for (int k = 0; k < 12; k++) begin
            hold = 1 + ((k == stall_word) ? stall_len : 0);
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                if (icap_ce_n === 1'b0) wr_cycles++;
                check($sformatf("w%0d_c%0d_data", k, j), 32'(icap_i), 32'(rev_bytes(exp_word(k, gen1, gen2))));
                check($sformatf("w%0d_c%0d_ce_wr", k, j), {30'd0, icap_ce_n, icap_wr_n}, 32'd0);
                check($sformatf("w%0d_c%0d_ack_busy", k, j), {30'd0, ack, busy}, 32'd1);
                icap_busy = (j < hold - 1);
                if (disturb) begin
                    req  = ((k + j) % 2 == 0);
                    slot = 2'(k);
                end
            end
        end
        icap_busy = 1'b0;
        req       = 1'b0;
        @(negedge clk);
        check("write_cycles", 32'(wr_cycles), 32'(exp_cycles));
        check("done_pulse", {30'd0, done, busy}, 32'd2);
        check_idle_outputs("done");
        @(negedge clk);
        check("after_done", {29'd0, done, busy, ack}, 32'd0);
        check_idle_outputs("after_done");
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b1;
        slot      = 2'd1;
        icap_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flags", {29'd0, ack, busy, done}, 32'd0);
        check_idle_outputs("rst");

        // Start-up guard with req held high from reset release, slot 1
        reset = 1'b0;
        wait_ack(40, n);
        check("startup_ack_cycle", 32'(n), 32'd16);
        check("startup_busy", 32'(busy), 32'd1);
        check_idle_outputs("ack_cycle");
        req = 1'b0;
        expect_words(16'h0000, 16'h0306, -1, 0, 1'b0, 12);
        check("slot1_aa99_raw", 32'(rev_bytes(16'hAA99)), 32'h00005599);

        // BUSY stall on word 3, slot 0
        req  = 1'b1;
        slot = 2'd0;
        wait_ack(5, n);
        check("slot0_ack_cycle", 32'(n), 32'd1);
        req = 1'b0;
        expect_words(16'h0000, 16'h0300, 3, 3, 1'b0, 15);

        // Slot 3 with req pulses and slot changes during the sequence
        req  = 1'b1;
        slot = 2'd3;
        wait_ack(5, n);
        check("slot3_ack_cycle", 32'(n), 32'd1);
        expect_words(16'h0000, 16'h0312, -1, 0, 1'b1, 12);

        // Reset asserted while word 6 is on the bus, then a fresh guard delay
        req  = 1'b1;
        slot = 2'd2;
        wait_ack(5, n);
        check("slot2_ack_cycle", 32'(n), 32'd1);
        req = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_w6", 32'(icap_i), 32'(rev_bytes(16'h30A1)));
        #2 reset = 1'b1;
        #1;
        check("midrst_flags", {29'd0, ack, busy, done}, 32'd0);
        check_idle_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b1;
        wait_ack(40, n);
        check("restart_ack_cycle", 32'(n), 32'd16);
        req = 1'b0;
        expect_words(16'h0000, 16'h030C, -1, 0, 1'b0, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
